// File: rtl/baud_gen_if.sv
// Divisor/control handshake and tick outputs between the UART datapath and baud_gen.
interface baud_gen_if;
  logic [15:0] div_buf;
  logic        buf_rdy;
  logic        resync;
  logic        rx_en;
  logic        mid_en;
  logic        tx_en;
  logic        running;

  modport master (
    output div_buf, buf_rdy, resync,
    input  rx_en, mid_en, tx_en, running
  );

  modport slave (
    input  div_buf, buf_rdy, resync,
    output rx_en, mid_en, tx_en, running
  );
endinterface

// File: rtl/baud_gen.sv
// Baud-rate tick generator: programmable divisor down-counter producing oversample,
// mid-bit and bit ticks, with glitch-free divisor reload and receiver phase resync.
module baud_gen #(
  parameter int OVS = 16,
  parameter int MID = OVS / 2 - 1
) (
  input logic     clk,
  input logic     rst,
  baud_gen_if.slave bus
);
  localparam int SW = $clog2(OVS);
  localparam logic [SW-1:0] MID_SUB  = SW'(MID);
  localparam logic [SW-1:0] LAST_SUB = SW'(OVS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [15:0]   act_div_r, act_div_s;
  logic [15:0]   pend_div_r, pend_div_s;
  logic          pend_vld_r, pend_vld_s;
  logic [15:0]   cnt_r, cnt_s;
  logic [SW-1:0] sub_r, sub_s;
  logic          rdy_d_r;
  logic          ld_s;
  logic          wrap_s;
  logic [15:0]   next_div_s;

  assign ld_s   = bus.buf_rdy & ~rdy_d_r;
  assign wrap_s = (state_r == RUN) && (cnt_r == 16'd0);

  // Divisor for a restart: a fresh load beats a pending one, which beats the active one.
  always_comb begin
    next_div_s = act_div_r;
    if (ld_s) begin
      next_div_s = bus.div_buf;
    end else if (pend_vld_r) begin
      next_div_s = pend_div_r;
    end else begin
      next_div_s = act_div_r;
    end
  end

  // Next-state logic for the IDLE/RUN controller and its counters.
  always_comb begin
    state_s    = state_r;
    act_div_s  = act_div_r;
    pend_div_s = pend_div_r;
    pend_vld_s = pend_vld_r;
    cnt_s      = cnt_r;
    sub_s      = sub_r;
    case (state_r)
      IDLE: begin
        if (ld_s && (bus.div_buf != 16'd0)) begin
          act_div_s  = bus.div_buf;
          cnt_s      = bus.div_buf - 16'd1;
          sub_s      = '0;
          pend_vld_s = 1'b0;
          state_s    = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (bus.resync || wrap_s) begin
          pend_vld_s = 1'b0;
          if (bus.resync) begin
            sub_s = '0;
          end else begin
            sub_s = sub_r + SW'(1);
          end
          // A zero divisor stops the generator after the current period.
          if (next_div_s == 16'd0) begin
            state_s = IDLE;
            cnt_s   = 16'd0;
            sub_s   = '0;
          end else begin
            act_div_s = next_div_s;
            cnt_s     = next_div_s - 16'd1;
          end
        end else begin
          cnt_s = cnt_r - 16'd1;
          if (ld_s) begin
            pend_div_s = bus.div_buf;
            pend_vld_s = 1'b1;
          end else begin
            pend_vld_s = pend_vld_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      act_div_r  <= 16'd0;
      pend_div_r <= 16'd0;
      pend_vld_r <= 1'b0;
      cnt_r      <= 16'd0;
      sub_r      <= '0;
      rdy_d_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      act_div_r  <= act_div_s;
      pend_div_r <= pend_div_s;
      pend_vld_r <= pend_vld_s;
      cnt_r      <= cnt_s;
      sub_r      <= sub_s;
      rdy_d_r    <= bus.buf_rdy;
    end
  end

  assign bus.rx_en   = wrap_s;
  assign bus.mid_en  = wrap_s && (sub_r == MID_SUB);
  assign bus.tx_en   = wrap_s && (sub_r == LAST_SUB);
  assign bus.running = (state_r == RUN);
endmodule

// File: tb/tb_baud_gen.sv
// Self-checking bench for baud_gen: anchor/period arithmetic model checked every cycle,
// plus directed scenarios with hand-computed pulse counts and spacings.
module tb_baud_gen;
  localparam int OVS = 16;
  localparam int MID = OVS / 2 - 1;

  logic clk = 1'b0;
  logic rst;
  baud_gen_if bus ();

  baud_gen #(.OVS(OVS), .MID(MID)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: ticks fall at anchor + m*period - 1; sub advances once per tick from m_s0.
  int edge_n = 0;
  bit m_run = 1'b0, m_rdy_d = 1'b0, m_pend_vld = 1'b0;
  int m_pend = 0, m_a = 0, m_p = 1, m_s0 = 0;
  bit e_rx = 1'b0, e_mid = 1'b0, e_tx = 1'b0;
  int e_sub = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, edge_n);
    end
  endtask

  task automatic model_step();
    int k;
    int newp;
    bit ld;
    edge_n++;
    ld   = bus.buf_rdy && !m_rdy_d;
    newp = ld ? int'(bus.div_buf) : (m_pend_vld ? m_pend : m_p);
    if (rst) begin
      m_run = 1'b0; m_rdy_d = 1'b0; m_pend_vld = 1'b0; m_pend = 0;
    end else begin
      m_rdy_d = bus.buf_rdy;
      if (!m_run) begin
        if (ld && bus.div_buf != 16'd0) begin
          m_run = 1'b1; m_a = edge_n; m_p = int'(bus.div_buf); m_s0 = 0; m_pend_vld = 1'b0;
        end
      end else if (bus.resync || e_rx) begin
        m_pend_vld = 1'b0;
        if (newp == 0) begin
          m_run = 1'b0;
        end else begin
          m_s0 = bus.resync ? 0 : (e_sub + 1) % OVS;
          m_a  = edge_n;
          m_p  = newp;
        end
      end else if (ld) begin
        m_pend = int'(bus.div_buf);
        m_pend_vld = 1'b1;
      end
    end
    k     = edge_n - m_a;
    e_rx  = m_run && (k % m_p == m_p - 1);
    e_sub = m_run ? (m_s0 + k / m_p) % OVS : 0;
    e_mid = e_rx && (e_sub == MID);
    e_tx  = e_rx && (e_sub == OVS - 1);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("rx_en", bus.rx_en, e_rx);
    chk("mid_en", bus.mid_en, e_mid);
    chk("tx_en", bus.tx_en, e_tx);
    chk("running", bus.running, m_run);
  endtask

  task automatic wait_rx(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (bus.rx_en === 1'b1) begin
        at = edge_n;
        break;
      end
    end
    if (at < 0) begin
      errors++;
      checks++;
      $display("FAIL wait_rx: no rx_en within %0d clocks", bound);
      at = edge_n;
    end
  endtask

  initial begin
    int load_e, r_e, t, t2, t3, nrx, ntx, nmid, first_mid, r;
    rst = 1'b1; bus.div_buf = 16'd0; bus.buf_rdy = 1'b0; bus.resync = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {bus.rx_en, bus.mid_en, bus.tx_en, bus.running}, 32'd0);
    rst = 1'b0;
    tick();

    // divisor 4 from IDLE
    bus.div_buf = 16'h0004; bus.buf_rdy = 1'b1;
    tick();
    load_e = edge_n;
    chk("load_running", bus.running, 32'd1);
    nrx = 0; ntx = 0; nmid = 0; first_mid = -1;
    for (int i = 0; i < 63; i++) begin
      tick();
      nrx += int'(bus.rx_en); ntx += int'(bus.tx_en); nmid += int'(bus.mid_en);
      if (bus.mid_en === 1'b1 && first_mid < 0) first_mid = edge_n - load_e;
    end
    chk("div4_rx_count", nrx, 32'd16);
    chk("div4_tx_count", ntx, 32'd1);
    chk("div4_mid_count", nmid, 32'd1);
    chk("div4_first_mid", first_mid, 32'd31);

    // reload 6 while cnt = 2
    bus.buf_rdy = 1'b0;
    tick(); tick();
    bus.div_buf = 16'd6; bus.buf_rdy = 1'b1;
    tick();
    wait_rx(10, t);
    chk("reload_cur_period", t - (load_e + 63), 32'd4);
    wait_rx(10, t2);
    chk("reload_new_period1", t2 - t, 32'd6);
    wait_rx(10, t3);
    chk("reload_new_period2", t3 - t2, 32'd6);

    // back to divisor 4, then resync at sub 5 / cnt 1
    bus.buf_rdy = 1'b0; tick();
    bus.div_buf = 16'd4; bus.buf_rdy = 1'b1; tick();
    bus.buf_rdy = 1'b0;
    r = 0;
    while (!(e_rx && e_sub == 4 && m_p == 4) && r < 200) begin
      tick();
      r++;
    end
    if (r >= 200) begin
      errors++; checks++;
      $display("FAIL resync_setup: sub 4 tick not reached in %0d clocks", r);
    end
    tick(); tick(); tick();
    bus.resync = 1'b1;
    tick();
    r_e = edge_n;
    bus.resync = 1'b0;
    chk("resync_no_pulse", bus.rx_en, 32'd0);
    wait_rx(10, t);
    chk("resync_first_rx", t - r_e, 32'd3);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.mid_en === 1'b1) begin
        t = edge_n;
        break;
      end
    end
    chk("resync_mid", t - r_e, 32'd31);

    // divisor 1
    bus.div_buf = 16'd1; bus.buf_rdy = 1'b1; tick();
    bus.buf_rdy = 1'b0;
    r = 0;
    while (m_p != 1 && r < 10) begin
      tick();
      r++;
    end
    nrx = 0; ntx = 0; nmid = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      nrx += int'(bus.rx_en); ntx += int'(bus.tx_en); nmid += int'(bus.mid_en);
    end
    chk("div1_rx_count", nrx, 32'd32);
    chk("div1_tx_count", ntx, 32'd2);
    chk("div1_mid_count", nmid, 32'd2);

    // zero load coinciding with a wrap stops the generator
    bus.div_buf = 16'd0; bus.buf_rdy = 1'b1; tick();
    chk("zero_at_wrap_stop", bus.running, 32'd0);
    // zero load from IDLE is ignored
    bus.buf_rdy = 1'b0; tick();
    bus.buf_rdy = 1'b1; tick();
    chk("idle_zero_ignored", bus.running, 32'd0);
    repeat (8) tick();

    // divisor 3, then pending zero mid-period
    bus.buf_rdy = 1'b0; tick();
    bus.div_buf = 16'd3; bus.buf_rdy = 1'b1; tick();
    chk("div3_running", bus.running, 32'd1);
    bus.buf_rdy = 1'b0; tick();
    bus.div_buf = 16'd0; bus.buf_rdy = 1'b1; tick();
    chk("zero_wrap_pulse", bus.rx_en, 32'd1);
    tick();
    chk("zero_then_idle", bus.running, 32'd0);

    // reset mid-run with buf_rdy held high
    bus.buf_rdy = 1'b0; tick();
    bus.div_buf = 16'h50AA; bus.buf_rdy = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("rst_outputs", {bus.rx_en, bus.mid_en, bus.tx_en, bus.running}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    load_e = edge_n;
    chk("relaunch_running", bus.running, 32'd1);
    wait_rx(21000, t);
    chk("big_first_rx", t - load_e, 32'd20649);
    wait_rx(21000, t2);
    chk("big_period", t2 - t, 32'd20650);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
